// File: rtl/shield_pkg.sv
// Shared definitions for the shield energy manager and the player/game logic
// that consumes it: state encoding, default tuning values, and the LED bar
// thermometer helper.
package shield_pkg;

    typedef enum logic [1:0] {
        ST_REGEN  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_BROKEN = 2'd3
    } shield_state_t;

    localparam int DEF_MAX_SHIELD          = 15;  // 4-bit meter, must stay <= 15
    localparam int DEF_DRAIN_STEP          = 1;
    localparam int DEF_HIT_COST            = 3;
    localparam int DEF_REGEN_DELAY_TICKS   = 2;   // must fit the 3-bit countdown
    localparam int DEF_BREAK_LOCKOUT_TICKS = 6;   // must fit the 3-bit countdown

    // LED bar segment i is lit while the meter is above 2*i.
    function automatic logic [7:0] thermo_bar(input logic [3:0] level);
        logic [7:0] bar;
        bar = '0;
        for (int i = 0; i < 8; i++) begin
            bar[i] = ({1'b0, level} > 5'(2 * i));
        end
        return bar;
    endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter used for both the regen delay and the guard-break
// lockout.
// Ports:
//   slowed_shield_clk  shield tick clock
//   reset              synchronous, active-low
//   load / load_value  load a new count (takes priority over dec)
//   dec                decrement by one; ignored at zero
//   count              current count
//   zero               count == 0
module tick_countdown #(
    parameter int W = 3
) (
    input  logic         slowed_shield_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register; reset is sampled on
    // the clock edge because the surrounding design resets synchronously.
    always_ff @(posedge slowed_shield_clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shield_energy.sv
// Per-player shield energy manager on the 2 Hz shield tick. Drains the meter
// while guarding, charges extra for absorbed hits, holds off regen briefly
// after the guard is released, and locks the guard out after the meter empties.
// Ports:
//   slowed_shield_clk  one edge per shield tick
//   reset              synchronous, active-low
//   shield_btn         guard button level
//   shielding          player action is SHIELDING
//   hit_blocked        a blocked hit is waiting to be absorbed
//   shield             current meter (registered)
//   shield_ok          guard usable: meter >= 1 and not broken (registered)
//   shield_broken      in the guard-break lockout (registered)
//   hit_ack            one-tick pulse: the pending hit was absorbed (registered)
//   shield_bar         LED thermometer of the meter (registered)
module shield_energy
    import shield_pkg::*;
#(
    parameter int MAX_SHIELD          = DEF_MAX_SHIELD,
    parameter int DRAIN_STEP          = DEF_DRAIN_STEP,
    parameter int HIT_COST            = DEF_HIT_COST,
    parameter int REGEN_DELAY_TICKS   = DEF_REGEN_DELAY_TICKS,
    parameter int BREAK_LOCKOUT_TICKS = DEF_BREAK_LOCKOUT_TICKS
) (
    input  logic       slowed_shield_clk,
    input  logic       reset,
    input  logic       shield_btn,
    input  logic       shielding,
    input  logic       hit_blocked,
    output logic [3:0] shield,
    output logic       shield_ok,
    output logic       shield_broken,
    output logic       hit_ack,
    output logic [7:0] shield_bar
);

    localparam logic [3:0] MAX4 = 4'(MAX_SHIELD);

    shield_state_t state, state_n;
    logic [3:0]    shield_n;
    logic          hit_ack_n;
    logic          engaged;
    logic [4:0]    cost5;
    logic [4:0]    regen5;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [2:0]    cnt_load_value, cnt_count;

    tick_countdown #(.W(3)) u_countdown (
        .slowed_shield_clk (slowed_shield_clk),
        .reset             (reset),
        .load              (cnt_load),
        .load_value        (cnt_load_value),
        .dec               (cnt_dec),
        .count             (cnt_count),
        .zero              (cnt_zero)
    );

    assign engaged = shield_btn & shielding & (shield != 4'd0);

    // Drain and regen are computed one bit wider than the meter so the
    // saturation checks see the true result.
    assign cost5  = 5'(DRAIN_STEP) + (hit_blocked ? 5'(HIT_COST) : 5'd0);
    assign regen5 = {1'b0, shield} + 5'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_n        = state;
        shield_n       = shield;
        hit_ack_n      = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;

        if (state == ST_BROKEN) begin
            // Only the button matters here; the exit waits for a release.
            shield_n = 4'd0;
            if (!cnt_zero) begin
                cnt_dec = 1'b1;
            end else if (!shield_btn) begin
                state_n = ST_REGEN;
            end
        end else if (engaged) begin
            hit_ack_n = hit_blocked;
            shield_n  = (cost5 >= {1'b0, shield}) ? 4'd0 : shield - cost5[3:0];
            if (shield_n == 4'd0) begin
                // Exhaustion wins over the hit; the ack still goes out.
                state_n        = ST_BROKEN;
                cnt_load       = 1'b1;
                cnt_load_value = 3'(BREAK_LOCKOUT_TICKS);
            end else begin
                state_n = ST_DRAIN;
            end
        end else begin
            case (state)
                ST_DRAIN: begin
                    state_n        = ST_DELAY;
                    cnt_load       = 1'b1;
                    cnt_load_value = 3'(REGEN_DELAY_TICKS);
                end
                ST_DELAY: begin
                    // Leave on the tick the count reaches zero (or if it
                    // was loaded as zero).
                    cnt_dec = 1'b1;
                    if (cnt_count <= 3'd1) begin
                        state_n = ST_REGEN;
                    end
                end
                default: begin
                    shield_n = (regen5 > {1'b0, MAX4}) ? MAX4 : regen5[3:0];
                end
            endcase
        end
    end

    always_ff @(posedge slowed_shield_clk) begin
        if (!reset) begin
            state         <= ST_REGEN;
            shield        <= MAX4;
            shield_ok     <= (MAX4 != 4'd0);
            shield_broken <= 1'b0;
            hit_ack       <= 1'b0;
            shield_bar    <= thermo_bar(MAX4);
        end else begin
            state         <= state_n;
            shield        <= shield_n;
            shield_ok     <= (shield_n != 4'd0) && (state_n != ST_BROKEN);
            shield_broken <= (state_n == ST_BROKEN);
            hit_ack       <= hit_ack_n;
            shield_bar    <= thermo_bar(shield_n);
        end
    end

endmodule

// File: tb/tb_shield_energy.sv
// Directed, table-driven bench for shield_energy with default parameters.
module tb_shield_energy;

    logic       slowed_shield_clk = 1'b0;
    logic       reset = 1'b0;
    logic       shield_btn = 1'b0;
    logic       shielding = 1'b0;
    logic       hit_blocked = 1'b0;
    logic [3:0] shield;
    logic       shield_ok;
    logic       shield_broken;
    logic       hit_ack;
    logic [7:0] shield_bar;

    int errors = 0;
    int checks = 0;

    shield_energy dut (
        .slowed_shield_clk (slowed_shield_clk),
        .reset             (reset),
        .shield_btn        (shield_btn),
        .shielding         (shielding),
        .hit_blocked       (hit_blocked),
        .shield            (shield),
        .shield_ok         (shield_ok),
        .shield_broken     (shield_broken),
        .hit_ack           (hit_ack),
        .shield_bar        (shield_bar)
    );

    always #5 slowed_shield_clk = ~slowed_shield_clk;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic       sh;
        logic       hit;
        logic [3:0] s;
        logic       ok;
        logic       br;
        logic       ack;
        logic [7:0] bar;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic btn, input logic sh,
                                input logic hit, input logic [3:0] s, input logic ok,
                                input logic br, input logic ack, input logic [7:0] bar);
        vec_t v;
        v.rst_n = rst_n; v.btn = btn; v.sh = sh; v.hit = hit;
        v.s = s; v.ok = ok; v.br = br; v.ack = ack; v.bar = bar;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one tick, then sample the registered outputs 1 time unit later.
    task automatic apply(input string name, input vec_t v);
        reset       = v.rst_n;
        shield_btn  = v.btn;
        shielding   = v.sh;
        hit_blocked = v.hit;
        @(posedge slowed_shield_clk);
        #1;
        check({name, " shield"}, 32'(shield), 32'(v.s));
        check({name, " flags"}, {29'd0, shield_ok, shield_broken, hit_ack},
              {29'd0, v.ok, v.br, v.ack});
        check({name, " bar"}, 32'(shield_bar), 32'(v.bar));
    endtask

    initial begin
        // Main sequence: reset, drain/delay/regen, hits, exhaustion via hit.
        //                  rst btn sh hit   s    ok br ack bar
        vecs.push_back(mk(0, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF)); // reset
        vecs.push_back(mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF)); // idle x3, saturated
        vecs.push_back(mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF));
        vecs.push_back(mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF));
        vecs.push_back(mk(1, 1, 1, 0, 4'd14, 1, 0, 0, 8'h7F)); // engage x3
        vecs.push_back(mk(1, 1, 1, 0, 4'd13, 1, 0, 0, 8'h7F));
        vecs.push_back(mk(1, 1, 1, 0, 4'd12, 1, 0, 0, 8'h3F));
        vecs.push_back(mk(1, 0, 0, 0, 4'd12, 1, 0, 0, 8'h3F)); // to DELAY
        vecs.push_back(mk(1, 0, 0, 0, 4'd12, 1, 0, 0, 8'h3F)); // delay tick 1
        vecs.push_back(mk(1, 0, 0, 0, 4'd12, 1, 0, 0, 8'h3F)); // delay tick 2 -> REGEN
        vecs.push_back(mk(1, 0, 0, 0, 4'd13, 1, 0, 0, 8'h7F)); // regen
        vecs.push_back(mk(1, 0, 0, 0, 4'd14, 1, 0, 0, 8'h7F));
        vecs.push_back(mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF));
        vecs.push_back(mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF)); // stays at max
        vecs.push_back(mk(1, 1, 0, 1, 4'd15, 1, 0, 0, 8'hFF)); // hit, not shielding
        vecs.push_back(mk(1, 1, 1, 1, 4'd11, 1, 0, 1, 8'h3F)); // hit: -4
        vecs.push_back(mk(1, 1, 1, 1, 4'd7,  1, 0, 1, 8'h0F)); // second hit
        vecs.push_back(mk(1, 1, 1, 0, 4'd6,  1, 0, 0, 8'h07));
        vecs.push_back(mk(1, 1, 1, 0, 4'd5,  1, 0, 0, 8'h07));
        vecs.push_back(mk(1, 1, 1, 1, 4'd1,  1, 0, 1, 8'h01)); // 5 with hit -> 1
        vecs.push_back(mk(1, 0, 0, 0, 4'd1,  1, 0, 0, 8'h01)); // to DELAY
        vecs.push_back(mk(1, 0, 0, 1, 4'd1,  1, 0, 0, 8'h01)); // hit while released
        vecs.push_back(mk(1, 0, 0, 0, 4'd1,  1, 0, 0, 8'h01)); // -> REGEN
        vecs.push_back(mk(1, 0, 0, 0, 4'd2,  1, 0, 0, 8'h01));
        vecs.push_back(mk(1, 1, 1, 1, 4'd0,  0, 1, 1, 8'h00)); // 2 with hit -> BROKEN + ack

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Button held through and past the lockout: stays broken, hits ignored.
        for (int i = 0; i < 10; i++)
            apply($sformatf("hold%0d", i), mk(1, 1, 1, 1, 4'd0, 0, 1, 0, 8'h00));
        apply("hold_release", mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 8'h00));
        apply("hold_regen1",  mk(1, 0, 0, 0, 4'd1, 1, 0, 0, 8'h01));

        // Lockout length with the button already released: 6 broken ticks.
        apply("lk_enter", mk(1, 1, 1, 1, 4'd0, 0, 1, 1, 8'h00));
        for (int i = 1; i <= 6; i++)
            apply($sformatf("lk_tick%0d", i), mk(1, 0, 0, 0, 4'd0, 0, 1, 0, 8'h00));
        apply("lk_exit",   mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 8'h00));
        apply("lk_regen1", mk(1, 0, 0, 0, 4'd1, 1, 0, 0, 8'h01));

        // Reset in the middle of a lockout.
        apply("rs_enter", mk(1, 1, 1, 0, 4'd0, 0, 1, 0, 8'h00));
        apply("rs_tick1", mk(1, 0, 0, 0, 4'd0, 0, 1, 0, 8'h00));
        apply("rs_tick2", mk(1, 0, 0, 0, 4'd0, 0, 1, 0, 8'h00));
        apply("rs_reset", mk(0, 1, 1, 1, 4'd15, 1, 0, 0, 8'hFF));
        apply("rs_after", mk(1, 0, 0, 0, 4'd15, 1, 0, 0, 8'hFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shield_energy.md
# shield_energy

Per-player shield energy manager running on the 2 Hz shield tick. It tracks the shield meter, drains it while the player holds an active guard, charges extra for blocked hits, and enforces a regen delay and a guard-break lockout. It sits directly upstream of the player action logic, which consumes `shield` and `shield_ok`. It also drives the shield LED bar.

## Interface
Parameters:
- `MAX_SHIELD`, 15: full meter value; must be ≤ 15 (4-bit meter).
- `DRAIN_STEP`, 1: energy removed per tick while guarding.
- `HIT_COST`, 3: extra energy removed on a tick where a blocked hit is consumed.
- `REGEN_DELAY_TICKS`, 2: ticks of no regen after releasing guard.
- `BREAK_LOCKOUT_TICKS`, 6: ticks the guard stays unusable after the meter hits 0.

Ports:
- `slowed_shield_clk` in 1: clock, one edge per shield tick.
- `reset` in 1: reset, synchronous, active-low.
- `shield_btn` in 1: guard button level.
- `shielding` in 1: player action is currently SHIELDING (level).
- `hit_blocked` in 1: game holds this high while a hit on a guarding player awaits resolution.
- `shield` out 4: current meter.
- `shield_ok` out 1: guard usable (`shield` ≥ 1 and not BROKEN).
- `shield_broken` out 1: state is BROKEN.
- `hit_ack` out 1: one-tick pulse; pending blocked hit was absorbed this tick.
- `shield_bar` out 8: thermometer, `shield_bar[i] = (shield > 2*i)`.

## Operation
- States: REGEN, DRAIN, DELAY, BROKEN. All outputs are registered.
- Reset values: state REGEN, `shield`=MAX_SHIELD, `shield_ok`=1, `shield_broken`=0, `hit_ack`=0, `shield_bar`=8'hFF, counter=0.
- `engaged = shield_btn & shielding & (shield != 0)`.
- In any non-BROKEN state, when `engaged` is true:
  - The meter loses `DRAIN_STEP + (hit_blocked ? HIT_COST : 0)` this tick, saturating at 0.
  - `hit_ack` equals `hit_blocked`.
  - Next state is DRAIN.
  - If the result is 0, next state is BROKEN instead, with counter = BREAK_LOCKOUT_TICKS.
- DRAIN with `engaged` false: go to DELAY, counter = REGEN_DELAY_TICKS, meter unchanged.
- DELAY with `engaged` false: meter held, counter decrements; on the tick the counter reaches 0, go to REGEN.
- REGEN with `engaged` false: meter +1 per tick, saturating at MAX_SHIELD.
- BROKEN:
  - Meter held at 0; `shield_ok`=0; inputs other than `shield_btn` are ignored; `hit_ack`=0.
  - Counter decrements to 0.
  - Exit to REGEN only on a tick where counter==0 and `shield_btn`==0. While the button stays held, the block remains BROKEN with counter 0.
  - The first regen increment happens on the tick after exit.
- `hit_blocked` while not engaged (including BROKEN): no ack and no cost. The game treats the hit as unblocked.
- Arithmetic: compute in 5 bits, clamp to [0, MAX_SHIELD].

## Timing
- All decisions are sampled on `posedge slowed_shield_clk`. Output latency is one tick from input sample.
- Inputs are levels and must be held at least one tick. The game holds `hit_blocked` until it sees `hit_ack` or releases the guard.
- `hit_ack` is high for exactly one tick per consumed tick. If `hit_blocked` is still high on the next tick, that is a second hit.
- Reset mid-operation (any state, any counter value) restores reset values on that edge.
- Simultaneous hit and meter exhaustion: BROKEN wins, and `hit_ack`=1 on that same tick.

## Structure
- `shield_pkg`: state encoding localparams (REGEN/DRAIN/DELAY/BROKEN) and default parameter values, shared with the player and game logic.
- One sub-module, `tick_countdown`: a loadable 3-bit down-counter with a `zero` flag, used for both the delay and lockout counts.

## Test plan
- Reset, idle 3 ticks -> `shield`=15, `shield_bar`=8'hFF, `shield_ok`=1, state REGEN.
- Engage 3 ticks, then release -> `shield` 14, 13, 12. Then held at 12 for 2 DELAY ticks, then 13, 14, 15, and it stays at 15.
- At `shield`=5, engage with `hit_blocked`=1 for one tick -> `shield`=1, `hit_ack`=1 for one tick, `shield_bar`=8'h01.
- At `shield`=2, engage with hit -> `shield`=0, BROKEN, `shield_ok`=0. Hold button for 10 ticks -> remains BROKEN. Release -> REGEN, then `shield`=1 on the next tick.
- `hit_blocked`=1 with `shielding`=0 -> `hit_ack` stays 0 and the meter is unchanged.
- Assert reset at lockout tick 3 of BROKEN -> next edge: `shield`=15, `shield_broken`=0, `shield_ok`=1.
